// File: rtl/unidade_controle_param.sv
// rtl/unidade_controle_param.sv - Moore control FSM for a round-based sequence game; optional play timeout via UNIDADE_CONTROLE_TIMEOUT_EN
module unidade_controle_param #(
    parameter int MAX_RODADAS    = 16,
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           iniciar,
    input  logic                           jogada,
    input  logic                           igual,
    input  logic                           fimRodada,
    input  logic                           modo,
    output logic                           zeraC,
    output logic                           contaC,
    output logic                           zeraR,
    output logic                           registraR,
    output logic                           zeraCL,
    output logic                           contaCL,
    output logic                           escreveM,
    output logic                           acertou,
    output logic                           errou,
    output logic                           errou_timeout,
    output logic                           pronto,
    output logic [$clog2(MAX_RODADAS)-1:0] rodada,
    output logic [3:0]                     db_estado,
    output logic                           db_timeout
);

    localparam int RW = $clog2(MAX_RODADAS);

    typedef enum logic [3:0] {
        INICIAL          = 4'h0,
        INICIALIZA       = 4'h1,
        INICIA_SEQUENCIA = 4'h2,
        ESPERA           = 4'h3,
        REGISTRA         = 4'h4,
        COMPARA          = 4'h5,
        PROXIMA          = 4'h6,
        FINAL_SEQUENCIA  = 4'h7,
        PROX_SEQUENCIA   = 4'h8,
        ESPERA_ESCRITA   = 4'h9,
        FINAL_ACERTO     = 4'hA,
        ESCREVE          = 4'hB,
        FINAL_TIMEOUT    = 4'hC,
        FINAL_ERRO       = 4'hE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            modo_r;
    logic [RW-1:0]   rodada_r;
    logic            fim_total;
    logic            fim_t;
    logic            em_final;

    assign fim_total = (rodada_r == RW'(MAX_RODADAS - 1));
    assign em_final  = (state == FINAL_ACERTO) || (state == FINAL_ERRO) ||
                       (state == FINAL_TIMEOUT);
    assign rodada    = rodada_r;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CICLOS);

    logic [TW-1:0] conta_t;

    assign fim_t = (conta_t == TW'(TIMEOUT_CICLOS - 1));

    // Wait-state timer: runs only while waiting for a play, cleared everywhere else
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conta_t <= '0;
        end else if (state == ESPERA || state == ESPERA_ESCRITA) begin
            if (!fim_t) begin
                conta_t <= conta_t + TW'(1);
            end
        end else begin
            conta_t <= '0;
        end
    end

    assign db_timeout    = fim_t;
    assign errou_timeout = (state == FINAL_TIMEOUT);
`else
    // No timer: fimT is held low for every legal TIMEOUT_CICLOS
    assign fim_t         = (TIMEOUT_CICLOS < 0);
    assign db_timeout    = 1'b0;
    assign errou_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= INICIAL;
        end else begin
            state <= next_state;
        end
    end

    // Mode is sampled only when a new game is launched
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            modo_r <= 1'b0;
        end else if (iniciar && (state == INICIAL || em_final)) begin
            modo_r <= modo;
        end
    end

    // Completed-round counter, saturating at the last round
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rodada_r <= '0;
        end else if (state == INICIALIZA) begin
            rodada_r <= '0;
        end else if (state == PROX_SEQUENCIA && !fim_total) begin
            rodada_r <= rodada_r + RW'(1);
        end
    end

    // Next-state logic
    always_comb begin
        next_state = INICIAL;
        case (state)
            INICIAL:          next_state = iniciar ? INICIALIZA : INICIAL;
            INICIALIZA:       next_state = INICIA_SEQUENCIA;
            INICIA_SEQUENCIA: next_state = ESPERA;
            ESPERA: begin
                if (fim_t)       next_state = FINAL_TIMEOUT;
                else if (jogada) next_state = REGISTRA;
                else             next_state = ESPERA;
            end
            REGISTRA:         next_state = COMPARA;
            COMPARA: begin
                if (!igual)         next_state = FINAL_ERRO;
                else if (fimRodada) next_state = FINAL_SEQUENCIA;
                else                next_state = PROXIMA;
            end
            PROXIMA:          next_state = ESPERA;
            FINAL_SEQUENCIA: begin
                if (fim_total)   next_state = FINAL_ACERTO;
                else if (modo_r) next_state = ESPERA_ESCRITA;
                else             next_state = PROX_SEQUENCIA;
            end
            PROX_SEQUENCIA:   next_state = INICIA_SEQUENCIA;
            ESPERA_ESCRITA: begin
                if (fim_t)       next_state = FINAL_TIMEOUT;
                else if (jogada) next_state = ESCREVE;
                else             next_state = ESPERA_ESCRITA;
            end
            ESCREVE:          next_state = PROX_SEQUENCIA;
            FINAL_ACERTO:     next_state = iniciar ? INICIALIZA : FINAL_ACERTO;
            FINAL_ERRO:       next_state = iniciar ? INICIALIZA : FINAL_ERRO;
            FINAL_TIMEOUT:    next_state = iniciar ? INICIALIZA : FINAL_TIMEOUT;
            default:          next_state = INICIAL;
        endcase
    end

    // Moore output decode
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        zeraCL    = 1'b0;
        contaCL   = 1'b0;
        escreveM  = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        pronto    = 1'b0;
        case (state)
            INICIAL: begin
                zeraC  = 1'b1;
                zeraR  = 1'b1;
                zeraCL = 1'b1;
            end
            INICIALIZA: begin
                zeraC  = 1'b1;
                zeraCL = 1'b1;
            end
            REGISTRA:       registraR = 1'b1;
            PROXIMA:        contaC    = 1'b1;
            PROX_SEQUENCIA: contaCL   = 1'b1;
            ESCREVE: begin
                registraR = 1'b1;
                escreveM  = 1'b1;
            end
            FINAL_ACERTO: begin
                acertou = 1'b1;
                pronto  = 1'b1;
            end
            FINAL_ERRO, FINAL_TIMEOUT: begin
                errou  = 1'b1;
                pronto = 1'b1;
            end
            default: ;
        endcase
    end

    // Debug state code; anything outside the legal set reads back as F
    always_comb begin
        db_estado = 4'hF;
        case (state)
            INICIAL, INICIALIZA, INICIA_SEQUENCIA, ESPERA, REGISTRA, COMPARA,
            PROXIMA, FINAL_SEQUENCIA, PROX_SEQUENCIA, ESPERA_ESCRITA,
            FINAL_ACERTO, ESCREVE, FINAL_TIMEOUT, FINAL_ERRO:
                db_estado = state;
            default:
                db_estado = 4'hF;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_param.sv
// tb/tb_unidade_controle_param.sv - directed self-checking bench for unidade_controle_param
module tb_unidade_controle_param;

    logic       clock;
    logic       reset;
    logic       iniciar, jogada, igual, fimRodada, modo;
    logic       zeraC, contaC, zeraR, registraR, zeraCL, contaCL, escreveM;
    logic       acertou, errou, errou_timeout, pronto;
    logic [0:0] rodada;
    logic [3:0] db_estado;
    logic       db_timeout;

    int checks = 0;
    int errors = 0;
    int ncl    = 0;
    int ncc    = 0;

    localparam logic [10:0] OUTS_INICIAL = 11'b10101000000;

    unidade_controle_param #(
        .MAX_RODADAS   (2),
        .TIMEOUT_CICLOS(8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .jogada       (jogada),
        .igual        (igual),
        .fimRodada    (fimRodada),
        .modo         (modo),
        .zeraC        (zeraC),
        .contaC       (contaC),
        .zeraR        (zeraR),
        .registraR    (registraR),
        .zeraCL       (zeraCL),
        .contaCL      (contaCL),
        .escreveM     (escreveM),
        .acertou      (acertou),
        .errou        (errou),
        .errou_timeout(errou_timeout),
        .pronto       (pronto),
        .rodada       (rodada),
        .db_estado    (db_estado),
        .db_timeout   (db_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [10:0] outs();
        return {zeraC, contaC, zeraR, registraR, zeraCL, contaCL, escreveM,
                acertou, errou, errou_timeout, pronto};
    endfunction

    task automatic apply(input logic [4:0] v);
        {iniciar, jogada, igual, fimRodada, modo} = v;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        ncl += int'(contaCL);
        ncc += int'(contaC);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        apply(5'b00000);
        #2;
        checks++;
        if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_state got %h exp 0", db_estado); end
        checks++;
        if (outs() !== OUTS_INICIAL) begin errors++; $display("FAIL reset_outs got %b exp %b", outs(), OUTS_INICIAL); end
        checks++;
        if (rodada !== 1'b0 || db_timeout !== 1'b0) begin errors++; $display("FAIL reset_cnt got rodada %b dbt %b exp 0 0", rodada, db_timeout); end
        apply(5'b10000);
        tick();
        checks++;
        if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_hold got %h exp 0", db_estado); end
        apply(5'b00000);
        #2 reset = 1'b1;
        tick();
        tick();
        checks++;
        if (db_estado !== 4'h0 || outs() !== OUTS_INICIAL) begin errors++; $display("FAIL idle_inicial got %h %b exp 0 %b", db_estado, outs(), OUTS_INICIAL); end
    endtask

    task automatic test_win();
        logic [8:0] vec [18];
        vec = '{{5'b10000, 4'h1}, {5'b00001, 4'h2}, {5'b00001, 4'h3}, {5'b01000, 4'h4},
                {5'b00000, 4'h5}, {5'b00110, 4'h7}, {5'b00001, 4'h8}, {5'b00000, 4'h2},
                {5'b00000, 4'h3}, {5'b01000, 4'h4}, {5'b00000, 4'h5}, {5'b00100, 4'h6},
                {5'b00000, 4'h3}, {5'b01000, 4'h4}, {5'b00000, 4'h5}, {5'b00110, 4'h7},
                {5'b00000, 4'hA}, {5'b00000, 4'hA}};
        ncl = 0;
        ncc = 0;
        for (int i = 0; i < 18; i++) begin
            apply(vec[i][8:4]);
            tick();
            checks++;
            if (db_estado !== vec[i][3:0]) begin errors++; $display("FAIL win_step%0d got %h exp %h", i, db_estado, vec[i][3:0]); end
        end
        checks++;
        if (acertou !== 1'b1 || pronto !== 1'b1 || errou !== 1'b0) begin errors++; $display("FAIL win_flags got ac %b pr %b er %b exp 1 1 0", acertou, pronto, errou); end
        checks++;
        if (rodada !== 1'b1) begin errors++; $display("FAIL win_rodada got %b exp 1", rodada); end
        checks++;
        if (ncl !== 1 || ncc !== 1) begin errors++; $display("FAIL win_pulses got contaCL %0d contaC %0d exp 1 1", ncl, ncc); end
    endtask

    task automatic test_error();
        logic [8:0] vec [13];
        vec = '{{5'b10000, 4'h1}, {5'b00000, 4'h2}, {5'b00000, 4'h3}, {5'b01000, 4'h4},
                {5'b00000, 4'h5}, {5'b00110, 4'h7}, {5'b00000, 4'h8}, {5'b00000, 4'h2},
                {5'b00000, 4'h3}, {5'b01000, 4'h4}, {5'b00000, 4'h5}, {5'b00000, 4'hE},
                {5'b00110, 4'hE}};
        for (int i = 0; i < 13; i++) begin
            apply(vec[i][8:4]);
            tick();
            checks++;
            if (db_estado !== vec[i][3:0]) begin errors++; $display("FAIL err_step%0d got %h exp %h", i, db_estado, vec[i][3:0]); end
        end
        checks++;
        if (outs() !== 11'b00000000101) begin errors++; $display("FAIL err_outs got %b exp 00000000101", outs()); end
        checks++;
        if (rodada !== 1'b1) begin errors++; $display("FAIL err_rodada got %b exp 1", rodada); end
        apply(5'b10000);
        tick();
        checks++;
        if (db_estado !== 4'h1) begin errors++; $display("FAIL err_restart got %h exp 1", db_estado); end
        apply(5'b00000);
        tick();
        checks++;
        if (db_estado !== 4'h2 || rodada !== 1'b0) begin errors++; $display("FAIL err_clear got %h rodada %b exp 2 0", db_estado, rodada); end
    endtask

    task automatic test_write();
        logic [8:0] vec [9];
        vec = '{{5'b10001, 4'h1}, {5'b00000, 4'h2}, {5'b00000, 4'h3}, {5'b01000, 4'h4},
                {5'b00000, 4'h5}, {5'b00110, 4'h7}, {5'b00000, 4'h9}, {5'b00000, 4'h9},
                {5'b01001, 4'hB}};
        reset = 1'b0;
        #3 reset = 1'b1;
        apply(5'b00000);
        tick();
        for (int i = 0; i < 9; i++) begin
            apply(vec[i][8:4]);
            tick();
            checks++;
            if (db_estado !== vec[i][3:0]) begin errors++; $display("FAIL wr_step%0d got %h exp %h", i, db_estado, vec[i][3:0]); end
        end
        checks++;
        if (outs() !== 11'b00010010000) begin errors++; $display("FAIL wr_escreve got %b exp 00010010000", outs()); end
        apply(5'b00000);
        tick();
        checks++;
        if (db_estado !== 4'h8 || outs() !== 11'b00000100000) begin errors++; $display("FAIL wr_prox got %h %b exp 8 00000100000", db_estado, outs()); end
        tick();
        checks++;
        if (db_estado !== 4'h2 || rodada !== 1'b1) begin errors++; $display("FAIL wr_next got %h rodada %b exp 2 1", db_estado, rodada); end
    endtask

    task automatic test_reset_mid();
        apply(5'b00000);
        tick();
        apply(5'b01000);
        tick();
        apply(5'b00110);
        tick();
        checks++;
        if (db_estado !== 4'h5) begin errors++; $display("FAIL mid_compara got %h exp 5", db_estado); end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (db_estado !== 4'h0 || rodada !== 1'b0 || outs() !== OUTS_INICIAL) begin
            errors++; $display("FAIL mid_async got %h rodada %b outs %b exp 0 0 %b", db_estado, rodada, outs(), OUTS_INICIAL);
        end
        #1 reset = 1'b1;
        apply(5'b00000);
        tick();
        checks++;
        if (db_estado !== 4'h0) begin errors++; $display("FAIL mid_resume got %h exp 0", db_estado); end
        apply(5'b10000);
        tick();
        checks++;
        if (db_estado !== 4'h1) begin errors++; $display("FAIL mid_start got %h exp 1", db_estado); end
    endtask

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    task automatic test_timeout();
        apply(5'b00000);
        tick();
        tick();
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (db_estado !== 4'h3 || db_timeout !== (k == 7)) begin
                errors++; $display("FAIL to_wait%0d got %h dbt %b exp 3 %b", k, db_estado, db_timeout, k == 7);
            end
        end
        tick();
        checks++;
        if (db_estado !== 4'hC || outs() !== 11'b00000000111) begin errors++; $display("FAIL to_final got %h %b exp C 00000000111", db_estado, outs()); end
        apply(5'b10000);
        tick();
        apply(5'b00000);
        tick();
        tick();
        checks++;
        if (db_estado !== 4'h3 || db_timeout !== 1'b0) begin errors++; $display("FAIL to_rearm got %h dbt %b exp 3 0", db_estado, db_timeout); end
        for (int k = 1; k <= 7; k++) tick();
        apply(5'b01000);
        tick();
        checks++;
        if (db_estado !== 4'hC || errou_timeout !== 1'b1) begin errors++; $display("FAIL to_priority got %h et %b exp C 1", db_estado, errou_timeout); end
    endtask
`else
    task automatic test_no_timeout();
        apply(5'b00000);
        tick();
        tick();
        for (int k = 0; k < 100; k++) begin
            tick();
            checks++;
            if (db_estado !== 4'h3 || db_timeout !== 1'b0 || errou_timeout !== 1'b0) begin
                errors++; $display("FAIL nto_idle%0d got %h dbt %b et %b exp 3 0 0", k, db_estado, db_timeout, errou_timeout);
            end
        end
        apply(5'b01000);
        tick();
        checks++;
        if (db_estado !== 4'h4) begin errors++; $display("FAIL nto_play got %h exp 4", db_estado); end
    endtask
`endif

    initial begin
        test_reset();
        test_win();
        test_error();
        test_write();
        test_reset_mid();
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle_param.md
UNIDADE_CONTROLE_PARAM -- requirements
Module: unidade_controle_param

Interface
REQ-001 SHALL have parameter MAX_RODADAS, default 16, number of rounds to win (range 2..256).
REQ-002 SHALL have parameter TIMEOUT_CICLOS, default 5000, max wait cycles per play (≥2).
REQ-003 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have inputs iniciar, jogada, igual, fimRodada, modo, each in 1: start, play strobe, play matches memory, address counter at round limit, mode (0 replay, 1 replay+write).
REQ-006 SHALL have outputs zeraC, contaC, zeraR, registraR, zeraCL, contaCL, escreveM, each out 1: datapath strobes.
REQ-007 SHALL have outputs acertou, errou, errou_timeout, pronto, each out 1: result flags.
REQ-008 SHALL have outputs rodada  out  $clog2(MAX_RODADAS)  completed-round count; db_estado  out  4  state code; db_timeout  out  1  fimT.

Function
REQ-009 SHALL be a Moore FSM; all outputs decoded from the state register only (plus the internal counters for rodada/db_timeout).
REQ-010 SHALL encode states: inicial 0, inicializa 1, inicia_sequencia 2, espera 3, registra 4, compara 5, proxima 6, final_sequencia 7, prox_sequencia 8, espera_escrita 9, escreve B, final_acerto A, final_erro E, final_timeout C; db_estado = code; unused codes -> inicial next cycle, db_estado F.
REQ-011 SHALL transition: inicial -iniciar-> inicializa; inicializa -> inicia_sequencia -> espera; registra -> compara; proxima -> espera; escreve -> prox_sequencia -> inicia_sequencia.
REQ-012 espera: fimT -> final_timeout, else jogada -> registra, else hold; fimT has priority over simultaneous jogada.
REQ-013 compara: !igual -> final_erro; igual & fimRodada -> final_sequencia; igual & !fimRodada -> proxima.
REQ-014 final_sequencia: fimTotal -> final_acerto; else modo_r ? espera_escrita : prox_sequencia.
REQ-015 espera_escrita: fimT -> final_timeout, else jogada -> escreve, else hold.
REQ-016 final_acerto/final_erro/final_timeout: iniciar -> inicializa, else hold.
REQ-017 modo_r SHALL latch modo on the edge leaving inicial or any final state via iniciar; modo changes at other times are ignored.
REQ-018 Internal round counter: cleared in inicializa, +1 in prox_sequencia, drives rodada; fimTotal = (rodada == MAX_RODADAS-1); no wrap past MAX_RODADAS-1.
REQ-019 Timeout counter: cleared in every state except espera/espera_escrita, +1 per cycle in them; fimT = (count == TIMEOUT_CICLOS-1), i.e. timeout entered exactly TIMEOUT_CICLOS cycles after entering the wait state.
REQ-020 Outputs: zeraC in inicial/inicializa; zeraR in inicial; zeraCL in inicial/inicializa; registraR in registra and escreve; contaC in proxima; contaCL in prox_sequencia; escreveM in escreve; acertou in final_acerto; errou in final_erro/final_timeout; errou_timeout in final_timeout; pronto in any final state.

Reset
REQ-021 reset low SHALL immediately force state inicial, round counter 0, timeout counter 0, modo_r 0, independent of clock.
REQ-022 While in reset: zeraC=zeraR=zeraCL=1, all other outputs 0, rodada 0, db_estado 0.
REQ-023 Reset asserted mid-round (any state) SHALL abandon the game; operation resumes from inicial on first rising edge after release.

Configuration
REQ-024 Macro UNIDADE_CONTROLE_TIMEOUT_EN defined: timeout counter and final_timeout path per REQ-012/015/019.
REQ-025 Macro undefined: no timeout counter synthesized, fimT constant 0, final_timeout unreachable, errou_timeout and db_timeout constant 0.

Verification (MAX_RODADAS=2, TIMEOUT_CICLOS=8, macro defined unless noted)
REQ-026 Reset low, iniciar pulse, 2 rounds all igual=1, modo=0 -> state A, acertou=1, pronto=1, rodada=1, contaCL pulsed once.
REQ-027 Round 1, compara with igual=0 -> state E, errou=1, pronto=1, errou_timeout=0; iniciar -> inicializa, rodada=0.
REQ-028 Enter espera, no jogada for 8 cycles -> state C on 8th edge, errou=1, errou_timeout=1; jogada and fimT same cycle -> C.
REQ-029 modo=1 latched, round 0 complete -> espera_escrita, jogada -> escreve with escreveM=1, registraR=1 one cycle, then prox_sequencia; modo toggled mid-game has no effect.
REQ-030 reset low during compara -> db_estado 0 asynchronously, rodada 0; macro undefined, 100 idle cycles in espera -> state stays 3.
